bin_to_bcd_seq: RTL

Multi-channel, parametrised, sequential binary-to-BCD converter. It uses iterative double-dabble (shift-add-3), processing one bit per clock for all channels in parallel. It replaces the fixed 6-bit, 2-digit, 3-channel combinational converter feeding the clock's seven-segment display path. It also serves wider counters such as the stopwatch, date and alarm fields. A valid/ready handshake on the input and a one-cycle done pulse on the output let it sit between the timekeeping counters and the display mux.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bin_to_bcd_seq_if.sv | 24 ++
 rtl/bin_to_bcd_seq_dabble_step.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 117 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// Holds the digit width, FSM state encoding and elaboration-time math helpers.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // 10^n, saturating at all-ones once it no longer fits in 64 bits
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            if (r > 64'd1844674407370955161)
                r = '1;
            else
                r = r * 64'd10;
        end
        return r;
    endfunction

    // ceil(log2(v)), never less than 1 so counters keep at least one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v)
            r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the timekeeping counters and the converter.
// The master drives requests; the slave (converter) returns BCD results.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*BIN_W-1:0]    bin_in;
    logic                         out_valid;
    logic [CHANNELS*DIGITS*4-1:0] bcd_out;
    logic [CHANNELS-1:0]          overflow;

    modport master (
        output in_valid, bin_in,
        input  in_ready, out_valid, bcd_out, overflow
    );

    modport slave (
        input  in_valid, bin_in,
        output in_ready, out_valid, bcd_out, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_dabble_step.sv
// One double-dabble iteration for a single channel: add-3 then shift left.
// Layout of the vector is {bcd digits, remaining binary bits}.
module dabble_step
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic [DIGITS*BCD_W+BIN_W-1:0] vec_i,
    output logic [DIGITS*BCD_W+BIN_W-1:0] vec_o
);
    localparam int VW = DIGITS * BCD_W + BIN_W;

    logic [VW-1:0] adj;

    // Correct each digit >= 5 so the doubling carries decimally, then shift
    always_comb begin
        adj = vec_i;
        for (int d = 0; d < DIGITS; d++) begin
            if (vec_i[BIN_W + d*BCD_W +: BCD_W] >= 4'd5)
                adj[BIN_W + d*BCD_W +: BCD_W] =
                    vec_i[BIN_W + d*BCD_W +: BCD_W] + 4'd3;
        end
        vec_o = {adj[VW-2:0], 1'b0};
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-channel iterative binary-to-BCD converter, one bit per clock.
// All channels shift together; a done pulse publishes the registered result.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int CHANNELS = 3
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int          BCD_BITS = DIGITS * BCD_W;
    localparam int          VW       = BCD_BITS + BIN_W;
    localparam int          CNT_W    = clog2(BIN_W + 1);
    localparam int          CMP_W    = (BIN_W > 64) ? BIN_W : 64;
    localparam logic [63:0] LIMIT    = pow10(DIGITS);
    // Beyond 19 digits no 64-bit-representable limit exists; never overflows
    localparam bit          CAN_OVF  = (DIGITS < 20);

    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [VW-1:0]                      work_q [CHANNELS];
    logic [VW-1:0]                      work_d [CHANNELS];
    logic [VW-1:0]                      work_nx [CHANNELS];
    logic [CHANNELS-1:0]                ovf_q, ovf_d;
    logic [CHANNELS-1:0]                ovfo_q, ovfo_d;
    logic [CHANNELS-1:0][BCD_BITS-1:0]  bcd_q, bcd_d;
    logic [CHANNELS-1:0][BIN_W-1:0]     bin_ch;

    assign bin_ch = bus.bin_in;

    function automatic logic over_lim(input logic [BIN_W-1:0] v);
        return CAN_OVF && (CMP_W'(v) >= CMP_W'(LIMIT));
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        dabble_step #(
            .BIN_W  (BIN_W),
            .DIGITS (DIGITS)
        ) u_step (
            .vec_i (work_q[c]),
            .vec_o (work_nx[c])
        );
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= '0;
            ovfo_q  <= '0;
            bcd_q   <= '0;
            for (int c = 0; c < CHANNELS; c++)
                work_q[c] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ovfo_q  <= ovfo_d;
            bcd_q   <= bcd_d;
            for (int c = 0; c < CHANNELS; c++)
                work_q[c] <= work_d[c];
        end
    end

    // Next-state: capture on accept, iterate BIN_W times, publish on last step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ovfo_d  = ovfo_q;
        bcd_d   = bcd_q;
        for (int c = 0; c < CHANNELS; c++)
            work_d[c] = work_q[c];
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        work_d[c] = {{BCD_BITS{1'b0}}, bin_ch[c]};
                        ovf_d[c]  = over_lim(bin_ch[c]);
                    end
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int c = 0; c < CHANNELS; c++)
                    work_d[c] = work_nx[c];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    for (int c = 0; c < CHANNELS; c++)
                        bcd_d[c] = work_nx[c][VW-1 -: BCD_BITS];
                    ovfo_d  = ovf_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: handshake decoded from state, results from holding registers
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.bcd_out   = bcd_q;
        bus.overflow  = ovfo_q;
    end

endmodule
